// File: rtl/encoder_param_ctrl.sv
// Rotary-encoder parameter editor: selects a slot, edits its shadow value and writes it over a
// valid/ready config bus. Optional step acceleration in EDIT/COMMIT under ENC_ACCEL_EN.
module encoder_param_ctrl #(
  parameter int unsigned NUM_PARAMS   = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned PARAM_MAX    = 255,
  parameter int unsigned DEBOUNCE_CYC = 120000,
  parameter int unsigned ACCEL_WIN    = 240000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enc_a,
  input  logic                          enc_b,
  input  logic                          enc_sw,
  output logic [$clog2(NUM_PARAMS)-1:0] sel_idx,
  output logic                          edit_mode,
  output logic [DATA_W-1:0]             cur_value,
  output logic                          cfg_valid,
  input  logic                          cfg_ready,
  output logic [$clog2(NUM_PARAMS)-1:0] cfg_addr,
  output logic [DATA_W-1:0]             cfg_data
);

  localparam int unsigned IdxW = $clog2(NUM_PARAMS);
  localparam int unsigned CntW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned ExtW = DATA_W + 5;

  typedef enum logic [1:0] {StSelect, StEdit, StCommit} state_e;

  logic [1:0]      a_sync_q, b_sync_q, sw_sync_q;
  logic            a_prev_q;
  logic            step_up_q, step_dn_q;
  logic            sw_stable_q, press_q;
  logic [CntW-1:0] db_cnt_q;

  // Synchronisers, A falling-edge detector and switch debouncer (idle/released = 1).
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sync_q    <= 2'b11;
      b_sync_q    <= 2'b11;
      sw_sync_q   <= 2'b11;
      a_prev_q    <= 1'b1;
      step_up_q   <= 1'b0;
      step_dn_q   <= 1'b0;
      sw_stable_q <= 1'b1;
      press_q     <= 1'b0;
      db_cnt_q    <= '0;
    end else begin
      a_sync_q  <= {a_sync_q[0], enc_a};
      b_sync_q  <= {b_sync_q[0], enc_b};
      sw_sync_q <= {sw_sync_q[0], enc_sw};
      a_prev_q  <= a_sync_q[1];
      step_up_q <= a_prev_q & ~a_sync_q[1] & b_sync_q[1];
      step_dn_q <= a_prev_q & ~a_sync_q[1] & ~b_sync_q[1];
      press_q   <= 1'b0;
      if (sw_sync_q[1] == sw_stable_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == CntW'(DEBOUNCE_CYC - 1)) begin
        db_cnt_q    <= '0;
        sw_stable_q <= sw_sync_q[1];
        press_q     <= ~sw_sync_q[1];
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  state_e            state_q, state_d;
  logic [IdxW-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] cfg_data_q, cfg_data_d;
  logic              cfg_valid_q, cfg_valid_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] param_q [NUM_PARAMS];
  logic [DATA_W-1:0] param_d [NUM_PARAMS];
  logic [3:0]        delta;
  logic              step_any;

  assign step_any = step_up_q | step_dn_q;

`ifdef ENC_ACCEL_EN
  localparam int unsigned AccW = $clog2(ACCEL_WIN + 1);
  logic [AccW-1:0] ivl_q;

  always_ff @(posedge clk) begin
    if (rst || step_any) begin
      ivl_q <= '0;
    end else if (ivl_q != AccW'(ACCEL_WIN)) begin
      ivl_q <= ivl_q + 1'b1;
    end
  end

  assign delta = (state_q != StSelect && ivl_q < AccW'(ACCEL_WIN)) ? 4'd8 : 4'd1;
`else
  assign delta = 4'd1;
`endif

  function automatic logic [DATA_W-1:0] apply_step(input logic [DATA_W-1:0] v,
                                                   input logic up, input logic [3:0] d);
    logic [ExtW-1:0] w;
    logic [ExtW-1:0] dx;
    w  = ExtW'(v);
    dx = ExtW'(d);
    if (up) begin
      w = w + dx;
      if (w > ExtW'(PARAM_MAX)) w = ExtW'(PARAM_MAX);
    end else begin
      w = (w < dx) ? '0 : w - dx;
    end
    return w[DATA_W-1:0];
  endfunction

  logic [DATA_W-1:0] step_nv;
  assign step_nv = apply_step(shadow_q, step_up_q, delta);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    shadow_d    = shadow_q;
    cfg_data_d  = cfg_data_q;
    cfg_valid_d = cfg_valid_q;
    pend_d      = pend_q;
    param_d     = param_q;
    unique case (state_q)
      StSelect: begin
        if (press_q) begin
          state_d  = StEdit;
          shadow_d = param_q[sel_q];
        end else if (step_up_q) begin
          sel_d = (sel_q == IdxW'(NUM_PARAMS - 1)) ? '0 : sel_q + 1'b1;
        end else if (step_dn_q) begin
          sel_d = (sel_q == '0) ? IdxW'(NUM_PARAMS - 1) : sel_q - 1'b1;
        end
      end
      StEdit: begin
        if (press_q) begin
          state_d = StSelect;
        end else if (step_any && step_nv != shadow_q) begin
          shadow_d    = step_nv;
          cfg_data_d  = step_nv;
          cfg_valid_d = 1'b1;
          state_d     = StCommit;
        end
      end
      StCommit: begin
        if (press_q) pend_d = 1'b1;
        else if (step_any) shadow_d = step_nv;
        if (cfg_valid_q && cfg_ready) begin
          param_d[sel_q] = cfg_data_q;
          // Keep writing until the slot matches the shadow; a pending press waits for that.
          if (shadow_d != cfg_data_q) begin
            cfg_data_d = shadow_d;
          end else begin
            cfg_valid_d = 1'b0;
            state_d     = pend_d ? StSelect : StEdit;
            pend_d      = 1'b0;
          end
        end
      end
      default: state_d = StSelect;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StSelect;
      sel_q       <= '0;
      shadow_q    <= '0;
      cfg_data_q  <= '0;
      cfg_valid_q <= 1'b0;
      pend_q      <= 1'b0;
      for (int i = 0; i < int'(NUM_PARAMS); i++) param_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      shadow_q    <= shadow_d;
      cfg_data_q  <= cfg_data_d;
      cfg_valid_q <= cfg_valid_d;
      pend_q      <= pend_d;
      param_q     <= param_d;
    end
  end

  assign sel_idx   = sel_q;
  assign edit_mode = (state_q != StSelect);
  assign cur_value = (state_q == StSelect) ? param_q[sel_q] : shadow_q;
  assign cfg_valid = cfg_valid_q;
  assign cfg_addr  = sel_q;
  assign cfg_data  = cfg_data_q;

endmodule

// File: tb/tb_encoder_param_ctrl.sv
// Directed bench for encoder_param_ctrl: transaction-level model of selection, editing and
// config writes, plus a per-cycle bus-protocol monitor.
module tb_encoder_param_ctrl;

  localparam int NP = 4;
  localparam int DW = 8;
  localparam int PMAX = 10;
  localparam int DB = 32;
  localparam int HOLD = 6;

  logic          clk = 1'b0;
  logic          rst, enc_a, enc_b, enc_sw, cfg_ready;
  logic [1:0]    sel_idx, cfg_addr;
  logic          edit_mode, cfg_valid;
  logic [DW-1:0] cur_value, cfg_data;

  encoder_param_ctrl #(
    .NUM_PARAMS(NP), .DATA_W(DW), .PARAM_MAX(PMAX), .DEBOUNCE_CYC(DB), .ACCEL_WIN(2)
  ) dut (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_sw(enc_sw),
    .sel_idx(sel_idx), .edit_mode(edit_mode), .cur_value(cur_value),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state
  int m_sel, m_edit, m_shadow, m_out, m_hold, m_pend, m_lastw;
  int m_param [NP];
  int exp_w [$];
  int obs_w [$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    m_sel = 0; m_edit = 0; m_shadow = 0; m_out = 0; m_hold = 0; m_pend = 0; m_lastw = -1;
    for (int i = 0; i < NP; i++) m_param[i] = 0;
    exp_w.delete();
    obs_w.delete();
  endtask

  task automatic model_step(input bit up);
    int nv;
    if (m_edit == 0) begin
      m_sel = up ? (m_sel + 1) % NP : (m_sel + NP - 1) % NP;
    end else begin
      nv = up ? ((m_shadow + 1 > PMAX) ? PMAX : m_shadow + 1)
              : ((m_shadow == 0) ? 0 : m_shadow - 1);
      if (nv != m_shadow) begin
        m_shadow = nv;
        if (m_hold != 0) begin
          if (m_out == 0) begin
            exp_w.push_back(m_sel * 256 + nv);
            m_lastw = nv;
            m_out = 1;
          end
        end else begin
          exp_w.push_back(m_sel * 256 + nv);
          m_param[m_sel] = nv;
        end
      end
    end
  endtask

  task automatic model_press();
    if (m_out != 0) m_pend = 1;
    else if (m_edit == 0) begin
      m_edit = 1;
      m_shadow = m_param[m_sel];
    end else m_edit = 0;
  endtask

  task automatic release_ready();
    cfg_ready = 1'b1;
    m_hold = 0;
    if (m_out != 0) begin
      m_out = 0;
      if (m_shadow != m_lastw) exp_w.push_back(m_sel * 256 + m_shadow);
      m_param[m_sel] = m_shadow;
      if (m_pend != 0) begin
        m_edit = 0;
        m_pend = 0;
      end
    end
    wait_cyc(10);
  endtask

  task automatic detent(input bit up);
    if (up) begin
      enc_a = 0; wait_cyc(HOLD); enc_b = 0; wait_cyc(HOLD);
      enc_a = 1; wait_cyc(HOLD); enc_b = 1; wait_cyc(HOLD);
    end else begin
      enc_b = 0; wait_cyc(HOLD); enc_a = 0; wait_cyc(HOLD);
      enc_b = 1; wait_cyc(HOLD); enc_a = 1; wait_cyc(HOLD);
    end
    model_step(up);
  endtask

  task automatic press();
    enc_sw = 0; wait_cyc(DB + 10);
    enc_sw = 1; wait_cyc(DB + 10);
    model_press();
  endtask

  task automatic check_state(input string tag);
    chk({tag, " sel_idx"}, int'(sel_idx), m_sel);
    chk({tag, " edit_mode"}, int'(edit_mode), m_edit);
    chk({tag, " cur_value"}, int'(cur_value), (m_edit != 0) ? m_shadow : m_param[m_sel]);
    chk({tag, " cfg_valid"}, int'(cfg_valid), m_out);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, " write count"}, obs_w.size(), exp_w.size());
    for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++)
      chk($sformatf("%s write%0d addr*256+data", tag, i), obs_w[i], exp_w[i]);
    obs_w.delete();
    exp_w.delete();
  endtask

  // Protocol monitor: request held stable until accepted, valid only while editing.
  logic          pv_valid = 0, pv_ready = 0, pv_rst = 1;
  logic [1:0]    pv_addr = 0;
  logic [DW-1:0] pv_data = 0;
  always @(negedge clk) begin
    if (!rst && !pv_rst && pv_valid && !pv_ready) begin
      tests++;
      if (!(cfg_valid && cfg_addr == pv_addr && cfg_data == pv_data)) begin
        fails++;
        $display("FAIL hold: got v=%0d a=%0d d=%0d, expected v=1 a=%0d d=%0d",
                 cfg_valid, cfg_addr, cfg_data, pv_addr, pv_data);
      end
    end
    if (!rst && cfg_valid) begin
      tests++;
      if (!edit_mode) begin
        fails++;
        $display("FAIL valid_in_edit: got edit_mode=0, expected 1");
      end
      if (cfg_ready) obs_w.push_back(int'(cfg_addr) * 256 + int'(cfg_data));
    end
    pv_valid = cfg_valid; pv_ready = cfg_ready; pv_rst = rst;
    pv_addr = cfg_addr; pv_data = cfg_data;
  end

  int sel_exp [5] = '{1, 2, 3, 0, 1};

  initial begin
    rst = 1; enc_a = 1; enc_b = 1; enc_sw = 1; cfg_ready = 1;
    model_reset();
    wait_cyc(3);
    rst = 0;
    wait_cyc(1);
    chk("reset sel_idx", int'(sel_idx), 0);
    chk("reset edit_mode", int'(edit_mode), 0);
    chk("reset cur_value", int'(cur_value), 0);
    chk("reset cfg_valid", int'(cfg_valid), 0);
    chk("reset cfg_addr", int'(cfg_addr), 0);
    chk("reset cfg_data", int'(cfg_data), 0);

    // SELECT wraps forward
    for (int i = 0; i < 5; i++) begin
      detent(1);
      check_state("select cw");
      chk("select literal", int'(sel_idx), sel_exp[i]);
    end
    check_writes("select");

    // Edit slot 1 with three writes
    press();
    check_state("enter edit");
    for (int i = 0; i < 3; i++) detent(1);
    check_state("edit 3cw");
    check_writes("edit 3cw");
    press();
    check_state("back to select");
    chk("param1 literal", int'(cur_value), 3);

    // Switch bounce shorter than the debounce window
    for (int i = 0; i < 50; i++) begin
      enc_sw = ~enc_sw;
      wait_cyc(DB / 4);
    end
    enc_sw = 1;
    wait_cyc(DB * 2);
    check_state("bounce");
    check_writes("bounce");

    // Lower saturation on slot 2
    detent(1);
    press();
    detent(0);
    detent(0);
    check_state("floor");
    check_writes("floor");

    // Upper saturation at PARAM_MAX
    for (int i = 0; i < PMAX; i++) detent(1);
    check_writes("climb");
    detent(1);
    check_state("ceiling");
    chk("ceiling literal", int'(cur_value), PMAX);
    check_writes("ceiling");
    press();
    detent(1);

    // Back-pressure: 4 steps coalesce into two writes
    press();
    cfg_ready = 0; m_hold = 1;
    detent(1);
    for (int i = 0; i < 3; i++) detent(1);
    wait_cyc(420);
    check_state("stalled");
    chk("stalled data literal", int'(cfg_data), 1);
    release_ready();
    check_state("released");
    check_writes("coalesce");

    // Press during COMMIT takes effect after the handshake
    cfg_ready = 0; m_hold = 1;
    detent(1);
    press();
    check_state("press in commit");
    release_ready();
    check_state("after commit press");
    chk("after commit literal", int'(cur_value), 5);
    check_writes("commit press");

    // Reset while a write is pending
    press();
    cfg_ready = 0; m_hold = 1;
    detent(1);
    check_state("pre reset");
    rst = 1;
    wait_cyc(1);
    chk("midreset cfg_valid", int'(cfg_valid), 0);
    chk("midreset sel_idx", int'(sel_idx), 0);
    chk("midreset edit_mode", int'(edit_mode), 0);
    rst = 0; cfg_ready = 1;
    model_reset();
    wait_cyc(2);
    for (int i = 0; i < NP; i++) begin
      check_state("post reset walk");
      detent(1);
    end
    check_writes("post reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
